// File: rtl/demux_12.sv
// Receive-side 2:1 deinterleaver: regroups an alternating lane-0/lane-1 word
// stream into parallel pairs, flagging lane-0 words dropped by gap or resync.
module demux_12 #(
  parameter int WIDTH   = 4,
  parameter int MAX_GAP = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             sync_in,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic             valid_out,
  output logic             err_timeout,
  output logic             err_sync,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             state_dbg
);

  // Handshake: no backpressure. valid_in qualifies data_in/sync_in for exactly
  // the cycle it is high; valid_out, err_timeout and err_sync are one-cycle
  // registered pulses, and data_0/data_1 hold until the next completed pair.

  localparam int GAP_W = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

  typedef enum logic [0:0] {
    EXP_L0 = 1'b0,
    EXP_L1 = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   hold;
  logic [GAP_W-1:0]   gap_cnt;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset_L) begin
      state       <= EXP_L0;
      hold        <= '0;
      gap_cnt     <= '0;
      data_0      <= '0;
      data_1      <= '0;
      valid_out   <= 1'b0;
      err_timeout <= 1'b0;
      err_sync    <= 1'b0;
      pair_cnt    <= '0;
    end else begin
      valid_out   <= 1'b0;
      err_timeout <= 1'b0;
      err_sync    <= 1'b0;
      case (state)
        EXP_L0: begin
          if (valid_in) begin
            hold    <= data_in;
            gap_cnt <= '0;
            state   <= EXP_L1;
          end
        end
        EXP_L1: begin
          if (valid_in) begin
            if (sync_in) begin
              // A sync-marked word restarts the pair; the held word is lost.
              err_sync <= 1'b1;
              hold     <= data_in;
              gap_cnt  <= '0;
            end else begin
              data_0    <= hold;
              data_1    <= data_in;
              valid_out <= 1'b1;
              pair_cnt  <= pair_cnt + 1'b1;
              state     <= EXP_L0;
            end
          end else if (gap_cnt == GAP_LAST) begin
            err_timeout <= 1'b1;
            state       <= EXP_L0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= EXP_L0;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_12.sv
// Scoreboard bench for demux_12: directed words with hand-computed expected
// events; a negedge monitor pops and compares every output pulse.
module tb_demux_12;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int REC_W = 2 + 2 * WIDTH + CNT_W;

  localparam logic [1:0] K_PAIR = 2'd1;
  localparam logic [1:0] K_TOUT = 2'd2;
  localparam logic [1:0] K_SYNC = 2'd3;

  logic             clk = 1'b0;
  logic             reset_L = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_in = 1'b0;
  logic             sync_in = 1'b0;
  logic [WIDTH-1:0] data_0, data_1;
  logic             valid_out, err_timeout, err_sync;
  logic [CNT_W-1:0] pair_cnt;
  logic             state_dbg;

  logic [WIDTH-1:0] data_0_b, data_1_b;
  logic             valid_out_b, err_timeout_b, err_sync_b;
  logic [1:0]       pair_cnt_b;
  logic             state_dbg_b;

  demux_12 #(.WIDTH(WIDTH), .MAX_GAP(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .sync_in(sync_in), .data_0(data_0), .data_1(data_1), .valid_out(valid_out),
    .err_timeout(err_timeout), .err_sync(err_sync), .pair_cnt(pair_cnt),
    .state_dbg(state_dbg)
  );

  // Narrow-counter instance shares the stimulus to exercise wrap-around.
  demux_12 #(.WIDTH(WIDTH), .MAX_GAP(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .sync_in(sync_in), .data_0(data_0_b), .data_1(data_1_b), .valid_out(valid_out_b),
    .err_timeout(err_timeout_b), .err_sync(err_sync_b), .pair_cnt(pair_cnt_b),
    .state_dbg(state_dbg_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [REC_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit track_b2b = 1'b0;
  bit have_last = 1'b0;
  int last_cyc = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    valid_in = v;
    sync_in  = s;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sync_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [WIDTH-1:0] d0,
                           input logic [WIDTH-1:0] d1, input logic [CNT_W-1:0] c);
    exp_q.push_back({k, d0, d1, c});
  endtask

  task automatic do_reset(input logic v, input logic [WIDTH-1:0] d);
    logic [2*WIDTH+CNT_W+3:0] got;
    reset_L = 1'b1;
    drive(v, 1'b0, d);
    reset_L = 1'b0;
    got = {data_0, data_1, valid_out, err_timeout, err_sync, pair_cnt, state_dbg};
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_state got=%h expected=0", got);
    end
    n_cmp++;
    if ({pair_cnt_b, valid_out_b, err_timeout_b, err_sync_b, state_dbg_b} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_state_b cnt=%0d vo=%b to=%b es=%b st=%b expected all 0",
               pair_cnt_b, valid_out_b, err_timeout_b, err_sync_b, state_dbg_b);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0]       kind;
    logic [REC_W-1:0] obs;
    logic [REC_W-1:0] exp_v;
    if (!reset_L && (valid_out || err_timeout || err_sync)) begin
      if (int'(valid_out) + int'(err_timeout) + int'(err_sync) != 1) kind = 2'd0;
      else if (valid_out)   kind = K_PAIR;
      else if (err_timeout) kind = K_TOUT;
      else                  kind = K_SYNC;
      obs = {kind, data_0, data_1, pair_cnt};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event at cyc %0d got kind=%0d d0=%h d1=%h cnt=%0d expected none",
                 cyc, kind, data_0, data_1, pair_cnt);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL event at cyc %0d got kind=%0d d0=%h d1=%h cnt=%0d expected kind=%0d d0=%h d1=%h cnt=%0d",
                   cyc, kind, data_0, data_1, pair_cnt, exp_v[REC_W-1 -: 2],
                   exp_v[2*WIDTH+CNT_W-1 -: WIDTH], exp_v[WIDTH+CNT_W-1 -: WIDTH], exp_v[CNT_W-1:0]);
        end
        if (valid_out) begin
          n_cmp++;
          if (!valid_out_b || pair_cnt_b !== exp_v[1:0]) begin
            n_bad++;
            $display("FAIL cnt_wrap got vo=%b cnt=%0d expected vo=1 cnt=%0d",
                     valid_out_b, pair_cnt_b, exp_v[1:0]);
          end
        end
      end
      if (valid_out && track_b2b) begin
        if (have_last) begin
          n_cmp++;
          if (cyc - last_cyc != 2) begin
            n_bad++;
            $display("FAIL b2b_spacing got %0d cycles expected 2", cyc - last_cyc);
          end
        end
        have_last = 1'b1;
        last_cyc  = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset(1'b0, '0);

    // T1: single pair
    expect_ev(K_PAIR, 4'h3, 4'hA, 8'd1);
    drive(1'b1, 1'b0, 4'h3);
    drive(1'b1, 1'b0, 4'hA);
    idle(2);

    // T2: back-to-back stream after a fresh reset
    do_reset(1'b0, '0);
    expect_ev(K_PAIR, 4'h1, 4'h2, 8'd1);
    expect_ev(K_PAIR, 4'h3, 4'h4, 8'd2);
    expect_ev(K_PAIR, 4'h5, 4'h6, 8'd3);
    expect_ev(K_PAIR, 4'h7, 4'h8, 8'd4);
    track_b2b = 1'b1;
    have_last = 1'b0;
    for (int w = 1; w <= 8; w++) drive(1'b1, 1'b0, WIDTH'(w));
    idle(1);
    track_b2b = 1'b0;

    // T3: tolerated gap, then a gap that times out, then recovery
    expect_ev(K_PAIR, 4'h5, 4'h6, 8'd5);
    drive(1'b1, 1'b0, 4'h5);
    idle(2);
    drive(1'b1, 1'b0, 4'h6);
    expect_ev(K_TOUT, 4'h5, 4'h6, 8'd5);
    drive(1'b1, 1'b0, 4'h5);
    idle(3);
    expect_ev(K_PAIR, 4'h7, 4'h8, 8'd6);
    drive(1'b1, 1'b0, 4'h7);
    drive(1'b1, 1'b0, 4'h8);
    idle(1);

    // T4: resync drops the held word; pair count advances once
    expect_ev(K_SYNC, 4'h7, 4'h8, 8'd6);
    expect_ev(K_PAIR, 4'h2, 4'h3, 8'd7);
    drive(1'b1, 1'b0, 4'h1);
    drive(1'b1, 1'b1, 4'h2);
    drive(1'b1, 1'b0, 4'h3);
    idle(1);

    // sync_in is don't-care on a lane-0 word and ignored while idle
    expect_ev(K_PAIR, 4'h4, 4'h5, 8'd8);
    drive(1'b1, 1'b1, 4'h4);
    drive(1'b1, 1'b0, 4'h5);
    expect_ev(K_PAIR, 4'h6, 4'h7, 8'd9);
    drive(1'b1, 1'b0, 4'h6);
    drive(1'b0, 1'b1, 4'hE);
    drive(1'b1, 1'b0, 4'h7);
    // a word on the last tolerated idle cycle still completes the pair
    expect_ev(K_PAIR, 4'hB, 4'hC, 8'd10);
    drive(1'b1, 1'b0, 4'hB);
    idle(2);
    drive(1'b1, 1'b0, 4'hC);
    idle(1);

    // T5: reset mid-pair with valid_in high, no error pulse
    drive(1'b1, 1'b0, 4'h9);
    do_reset(1'b1, 4'hF);
    expect_ev(K_PAIR, 4'h4, 4'h5, 8'd1);
    drive(1'b1, 1'b0, 4'h4);
    drive(1'b1, 1'b0, 4'h5);
    idle(5);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending events expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish expected completion");
    $fatal(1, "time limit");
  end

endmodule
